// File: rtl/brcomp_pkg.sv
// Shared types and the branch-condition decode for the iterative branch comparator.
package brcomp_pkg;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic less;
        logic equal;
        logic taken;
    } res_t;

    function automatic logic taken_f(input logic [2:0] funct3, input logic less, input logic eq);
        case (funct3)
            BEQ:        return eq;
            BNE:        return !eq;
            BLT, BLTU:  return less;
            BGE, BGEU:  return !less;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brcomp_chunk.sv
// Combinational W-bit compare; flip_msb turns the unsigned compare into a signed one.
module brcomp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flip_msb,
    output logic         less,
    output logic         equal
);

    logic [W-1:0] msk;

    always_comb begin
        msk        = '0;
        msk[W-1]   = flip_msb;
    end

    assign less  = (a ^ msk) < (b ^ msk);
    assign equal = (a == b);

endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle MSB-chunk-first branch comparator with valid/ready on both sides.
// BRCOMP_EARLY_EXIT_EN: stop at the first differing chunk; otherwise fixed NCHUNK-cycle latency.
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            br_unsigned,
    input  logic [2:0]      br_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            br_less,
    output logic            br_equal,
    output logic            br_taken
);

    localparam int CSAFE  = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK = XLEN / CSAFE;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (XLEN % CSAFE != 0)) begin : g_bad_cfg
            $error("brcomp_iter: CHUNK must be >= 1 and divide XLEN");
        end
    endgenerate

    state_t          state, state_n;
    logic [XLEN-1:0] a_q, b_q;
    logic            uns_q;
    logic [2:0]      f3_q;
    logic [IW-1:0]   idx;
    logic            decided;
    res_t            res_q, res_n;
    logic [CHUNK-1:0] ca, cb;
    logic            c_less, c_eq, last, accept, flip;

    assign ca     = a_q[idx*CHUNK +: CHUNK];
    assign cb     = b_q[idx*CHUNK +: CHUNK];
    assign last   = (idx == '0);
    assign flip   = !uns_q && (idx == TOP);
    assign accept = req_valid && req_ready;

    brcomp_chunk #(.W(CHUNK)) u_chunk (
        .a        (ca),
        .b        (cb),
        .flip_msb (flip),
        .less     (c_less),
        .equal    (c_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = CMP;
`ifdef BRCOMP_EARLY_EXIT_EN
            CMP:  if (!c_eq || last) state_n = DONE;
`else
            CMP:  if (last) state_n = DONE;
`endif
            DONE: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // First differing chunk decides; later chunks cannot override it (fixed-latency mode).
    always_comb begin
        res_n = res_q;
        if (!decided) begin
            if (!c_eq) begin
                res_n.less  = c_less;
                res_n.equal = 1'b0;
            end else if (last) begin
                res_n.less  = 1'b0;
                res_n.equal = 1'b1;
            end
            res_n.taken = taken_f(f3_q, res_n.less, res_n.equal);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            f3_q    <= '0;
            idx     <= '0;
            decided <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            uns_q   <= br_unsigned;
            f3_q    <= br_funct3;
            idx     <= TOP;
            decided <= 1'b0;
        end else if (state == CMP && !flush) begin
            res_q <= res_n;
            if (!c_eq || last) decided <= 1'b1;
            if (!last)         idx     <= idx - 1'b1;
        end
    end

    always_comb begin
        req_ready = (state == IDLE) && !flush;
        rsp_valid = (state == DONE);
        br_less   = res_q.less;
        br_equal  = res_q.equal;
        br_taken  = res_q.taken;
    end

endmodule

// File: tb/tb_brcomp_iter.sv
// Scoreboard bench for brcomp_iter: directed vectors, backpressure, flush and reset cases.
module tb_brcomp_iter;
    import brcomp_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, br_unsigned;
    logic [31:0] rs1_data, rs2_data;
    logic [2:0]  br_funct3;
    logic        rsp_valid, rsp_ready, br_less, br_equal, br_taken;

    brcomp_iter #(.XLEN(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .br_unsigned(br_unsigned), .br_funct3(br_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .br_less(br_less), .br_equal(br_equal), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic less;
        logic equal;
        logic taken;
        int   lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [2:0]  f;
        logic        l;
        logic        e;
        logic        t;
        int          le;
        int          lf;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency measured from the cycle the handshake is sampled.
    int       acc_cyc = 0;
    bit       in_rsp = 0;
    exp_t     cur;
    logic [2:0] held;

    always @(negedge clk) begin
        if (req_valid && req_ready && !rst) acc_cyc = cyc;
        if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1;
                held = {br_less, br_equal, br_taken};
                check("rsp_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("br_less",  br_less,  cur.less);
                    check("br_equal", br_equal, cur.equal);
                    check("br_taken", br_taken, cur.taken);
                    check("latency",  cyc - acc_cyc, cur.lat);
                end
            end else begin
                check("hold_stable", {29'd0, br_less, br_equal, br_taken}, {29'd0, held});
            end
            check("req_ready_in_done", req_ready, 0);
        end else begin
            in_rsp = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("ready_timeout", req_ready, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("rsp_timeout", sb.size(), 0);
    endtask

    task automatic drive(input vec_t v);
        rs1_data    = v.a;
        rs2_data    = v.b;
        br_unsigned = v.u;
        br_funct3   = v.f;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        rs1_data    = $urandom;
        rs2_data    = $urandom;
        br_unsigned = 1'($urandom);
        br_funct3   = 3'($urandom);
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        e.less  = v.l;
        e.equal = v.e;
        e.taken = v.t;
`ifdef BRCOMP_EARLY_EXIT_EN
        e.lat = v.le;
`else
        e.lat = v.lf;
`endif
        wait_ready();
        sb.push_back(e);
        drive(v);
    endtask

    vec_t vecs[10] = '{
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 2, 5},
        '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 2, 5},
        '{32'h12345678, 32'h12345678, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 5, 5},
        '{32'h12345678, 32'h12345678, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 5, 5},
        '{32'h00000100, 32'h00000101, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 5, 5},
        '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 2, 5},
        '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 2, 5},
        '{32'h12345678, 32'h12345678, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 5, 5},
        '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 5, 5},
        '{32'h01000000, 32'h00FFFFFF, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 2, 5}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        rs1_data = '0; rs2_data = '0; br_unsigned = 1'b0; br_funct3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outputs", {br_less, br_equal, br_taken}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i]);
            wait_done();
        end

        // Backpressure: hold rsp_ready low for 3 cycles while DONE.
        rsp_ready = 1'b0;
        issue(vecs[0]);
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) check("bp_rsp_timeout", rsp_valid, 1);
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done();

        // Flush during cycle 2 of an equal-operand compare.
        wait_ready();
        drive(vecs[2]);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_req_ready", req_ready, 1);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= rsp_valid; end
        check("flush_no_rsp", 32'(seen), 0);
        @(posedge clk); #1;

        // Reset pulse mid-CMP after a result left outputs nonzero.
        issue(vecs[8]);
        wait_done();
        wait_ready();
        drive(vecs[0]);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_outputs", {br_less, br_equal, br_taken}, 0);
        check("rst_mid_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // flush together with req_valid: request must be dropped.
        rs1_data = 32'hFFFFFFFF; rs2_data = 32'h1; br_unsigned = 1'b0; br_funct3 = 3'b100;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_req_req_ready", req_ready, 1);
        seen = 0;
        repeat (6) begin @(negedge clk); seen |= rsp_valid; end
        check("flush_req_no_rsp", 32'(seen), 0);
        @(posedge clk); #1;

        issue(vecs[2]);
        wait_done();
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brcomp_iter.md
Name: brcomp_iter

Overview:
- Parametrised, multi-cycle successor to the combinational branch comparator.
- Compares rs1/rs2 MSB-chunk-first, CHUNK bits per cycle, so wide XLEN does not sit on the execute critical path.
- Handles signed and unsigned comparison correctly and resolves the RISC-V branch condition (br_taken) from funct3.
- Sits in execute, between the operand muxes and the PC-select logic, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand width.
- CHUNK, 8, bits compared per cycle. XLEN % CHUNK must equal 0 and CHUNK >= 1; a violation triggers an elaboration error.
- NCHUNK, XLEN/CHUNK, derived localparam; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills any in-flight compare.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE with flush low.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- br_unsigned  in  1  1 = unsigned compare, 0 = two's-complement compare.
- br_funct3  in  3  branch condition.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- br_less  out  1  A < B in the selected mode.
- br_equal  out  1  A == B.
- br_taken  out  1  branch condition true.

Behaviour:
- Reset: state=IDLE. rsp_valid, br_less, br_equal, br_taken and chunk index all 0. req_ready=1 in the cycle after rst deasserts.
- Handshake and capture:
  - Accept when req_valid & req_ready. Latch rs1, rs2, br_unsigned and funct3; set idx=NCHUNK-1; go to CMP.
  - Inputs are ignored outside the accept cycle.
- CMP state, one chunk per cycle, starting at idx=NCHUNK-1:
  - The chunk at idx is compared. On the top chunk in signed mode, the MSB of both operands is inverted before an unsigned chunk compare.
  - Chunks differ: br_less=(a<b), br_equal=0, go to DONE.
  - Chunks equal and idx==0: br_equal=1, br_less=0, go to DONE.
  - Otherwise: idx decrements.
- DONE state:
  - rsp_valid=1, and outputs are held stable until rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid is low the next cycle.
  - No back-to-back accept from DONE; next acceptance is the earliest cycle after the IDLE transition.
- Latency, counting the accept edge as cycle 0: rsp_valid rises at cycle k+1, where k is the number of CMP cycles (1..NCHUNK).
  - Differing top chunk: rsp_valid at cycle 2.
  - Equal operands: rsp_valid at cycle NCHUNK+1.
- br_taken decode on funct3:
  - 000 = eq.
  - 001 = !eq.
  - 100 and 110 = less.
  - 101 and 111 = !less.
  - 010 and 011 = 0.
  - The control path drives br_unsigned = funct3[1]. br_taken uses the latched br_unsigned, not funct3[1].
- Flush:
  - In any state, next state=IDLE and rsp_valid=0 the following cycle; results are discarded.
  - flush & req_valid in the same cycle: the request is not accepted.
  - flush has priority over rsp_ready.
- rst mid-operation: same effect as flush, and all outputs are also cleared.
- CHUNK==XLEN: exactly one CMP cycle; rsp_valid at cycle 2.

Optional Feature:
- Macro BRCOMP_EARLY_EXIT_EN.
- Defined: early termination on the first differing chunk, as described above.
- Undefined: fixed latency.
  - The result is decided at the first differing chunk and frozen in holding flops.
  - All NCHUNK CMP cycles always run; rsp_valid is always at cycle NCHUNK+1.
  - This mode serves timing-predictable pipelines.

Decomposition:
- brcomp_pkg:
  - State enum: IDLE, CMP, DONE.
  - funct3 localparams: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Function taken_f(funct3, less, eq).
- Sub-module brcomp_chunk: combinational CHUNK-bit compare with a flip_msb input, producing less and equal. One instance, muxed by idx.

Test Plan:
- XLEN=32, CHUNK=8, signed, rs1=0xFFFFFFFF(-1), rs2=0x00000001, funct3=100 -> rsp_valid at cycle 2, br_less=1, br_equal=0, br_taken=1. Fixed-latency build: rsp_valid at cycle 5.
- Same operands, unsigned, funct3=110 -> br_less=0, br_taken=0, rsp_valid at cycle 2.
- rs1=rs2=0x12345678, funct3=000 -> rsp_valid at cycle 5, br_equal=1, br_taken=1. funct3=001 -> br_taken=0.
- rs1=0x00000100, rs2=0x00000101, unsigned, funct3=111 -> differs at chunk 0, rsp_valid at cycle 5, br_less=1, br_taken=0.
- Backpressure: rsp_ready=0 for 3 cycles -> outputs stable and req_ready=0 throughout. flush asserted in cycle 2 of a 4-chunk compare -> rsp_valid never rises, req_ready=1 the next cycle.
- rst pulse mid-CMP -> all outputs 0 the next cycle. flush & req_valid together -> not accepted, req_ready=1 the next cycle.
